// File: rtl/unified_mem_arbiter_pkg.sv
// ============================================================================
// unified_mem_arbiter_pkg
// Shared types and constants for the IF/DM unified memory arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package unified_mem_arbiter_pkg;

  localparam int ARB_MAX_DM_STREAK = 4;
  localparam int ARB_STREAK_W      = $clog2(ARB_MAX_DM_STREAK + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_WAIT = 2'd1,
    DM_WAIT = 2'd2,
    IF_DROP = 2'd3
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/unified_mem_arbiter_if.sv
// ============================================================================
// unified_mem_arbiter_if
// Fetch, data and memory-side handshake signals of the unified arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface unified_mem_arbiter_if #(
  parameter int AW = 64,
  parameter int DW = 64
);

  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic            if_flush;
  logic            if_gnt;
  logic            if_rvalid;
  logic [DW-1:0]   if_rdata;

  logic            dm_req;
  logic            dm_we;
  logic [AW-1:0]   dm_addr;
  logic [DW/8-1:0] dm_wmask;
  logic [DW-1:0]   dm_wdata;
  logic            dm_gnt;
  logic            dm_rvalid;
  logic [DW-1:0]   dm_rdata;

  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW/8-1:0] mem_wmask;
  logic [DW-1:0]   mem_wdata;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [DW-1:0]   mem_rdata;

  logic            busy;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, if_flush,
    output if_gnt, if_rvalid, if_rdata,
    input  dm_req, dm_we, dm_addr, dm_wmask, dm_wdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output mem_req, mem_we, mem_addr, mem_wmask, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output busy
  );

  // Requesters and memory side
  modport master (
    output if_req, if_addr, if_flush,
    input  if_gnt, if_rvalid, if_rdata,
    output dm_req, dm_we, dm_addr, dm_wmask, dm_wdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  mem_req, mem_we, mem_addr, mem_wmask, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  busy
  );

endinterface

`default_nettype wire

// File: rtl/unified_mem_arbiter_pick.sv
// ============================================================================
// mem_arb_pick
// Combinational candidate selection: DM first unless the IF streak saturated.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_arb_pick (
  input  logic if_ok,
  input  logic dm_req,
  input  logic streak_sat,
  output logic pick_if,
  output logic pick_dm
);

  assign pick_if = if_ok & (~dm_req | streak_sat);
  assign pick_dm = dm_req & ~pick_if;

endmodule

`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
// ============================================================================
// unified_mem_arbiter
// Shares one single-ported memory between fetch and load/store, one
// outstanding transaction, DM priority with IF anti-starvation and flush.
// Revision: 1.0
// ============================================================================
`default_nettype none

module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int AW            = 64,
  parameter int DW            = 64,
  parameter int MAX_DM_STREAK = ARB_MAX_DM_STREAK
) (
  input  logic                 clk,
  input  logic                 rst,
  unified_mem_arbiter_if.slave bus
);

  localparam int                    c_STREAK_W   = $clog2(MAX_DM_STREAK + 1);
  localparam logic [c_STREAK_W-1:0] c_STREAK_MAX = c_STREAK_W'(MAX_DM_STREAK);

  arb_state_t            r_state;
  arb_state_t            w_state_nxt;
  logic [c_STREAK_W-1:0] r_streak;
  logic [c_STREAK_W-1:0] w_streak_nxt;

  logic w_if_ok;
  logic w_streak_sat;
  logic w_pick_if;
  logic w_pick_dm;
  logic w_sel_if;
  logic w_sel_dm;
  logic w_can_issue;
  logic w_mem_req;
  logic w_if_gnt;
  logic w_dm_gnt;

  assign w_if_ok      = bus.if_req & ~bus.if_flush;
  assign w_streak_sat = (r_streak >= c_STREAK_MAX);

  mem_arb_pick u_pick (
    .if_ok      (w_if_ok),
    .dm_req     (bus.dm_req),
    .streak_sat (w_streak_sat),
    .pick_if    (w_pick_if),
    .pick_dm    (w_pick_dm)
  );

  // Every output is forced low while reset is held, independent of inputs.
  assign w_sel_if    = ~rst & w_pick_if;
  assign w_sel_dm    = ~rst & w_pick_dm;

  // A retiring response frees the port in the same cycle for back-to-back issue.
  assign w_can_issue = (r_state == IDLE) | bus.mem_rvalid;
  assign w_mem_req   = w_can_issue & (w_sel_if | w_sel_dm);
  assign w_if_gnt    = w_mem_req & bus.mem_gnt & w_sel_if;
  assign w_dm_gnt    = w_mem_req & bus.mem_gnt & w_sel_dm;

  assign bus.mem_req = w_mem_req;
  assign bus.if_gnt  = w_if_gnt;
  assign bus.dm_gnt  = w_dm_gnt;

  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wmask = '0;
    bus.mem_wdata = '0;
    if (w_sel_dm) begin
      bus.mem_we    = bus.dm_we;
      bus.mem_addr  = bus.dm_addr;
      bus.mem_wmask = bus.dm_wmask;
      bus.mem_wdata = bus.dm_wdata;
    end else if (w_sel_if) begin
      bus.mem_addr  = bus.if_addr;
    end
  end

  // A flush arriving with the response swallows it just like IF_DROP does.
  assign bus.if_rvalid = ~rst & bus.mem_rvalid & (r_state == IF_WAIT) & ~bus.if_flush;
  assign bus.dm_rvalid = ~rst & bus.mem_rvalid & (r_state == DM_WAIT);
  assign bus.if_rdata  = rst ? '0 : bus.mem_rdata;
  assign bus.dm_rdata  = rst ? '0 : bus.mem_rdata;
  assign bus.busy      = (r_state != IDLE);

  always_comb begin
    w_state_nxt = r_state;
    if (w_if_gnt) begin
      w_state_nxt = IF_WAIT;
    end else if (w_dm_gnt) begin
      w_state_nxt = DM_WAIT;
    end else if (bus.mem_rvalid) begin
      w_state_nxt = IDLE;
    end else if ((r_state == IF_WAIT) && bus.if_flush) begin
      w_state_nxt = IF_DROP;
    end
  end

  always_comb begin
    w_streak_nxt = r_streak;
    if (w_if_gnt | ~bus.if_req) begin
      w_streak_nxt = '0;
    end else if (w_dm_gnt & ~w_streak_sat) begin
      w_streak_nxt = r_streak + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_streak <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_streak <= w_streak_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
// ============================================================================
// tb_unified_mem_arbiter
// Directed scenarios plus randomized traffic against a transaction-level model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_unified_mem_arbiter;

  localparam int AW   = 64;
  localparam int DW   = 64;
  localparam int MAXS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  unified_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  unified_mem_arbiter #(
    .AW            (AW),
    .DW            (DW),
    .MAX_DM_STREAK (MAXS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the single outstanding transaction (0 none, 1 fetch,
  // 2 data, 3 flushed fetch) and how many DM grants IF has waited through.
  int          owner  = 0;
  int          streak = 0;
  logic        e_if_gnt = 1'b0;
  logic        e_dm_gnt = 1'b0;
  logic        m_pick_if, m_pick_dm, m_req, m_ifrv, m_dmrv, m_we;
  logic [63:0] m_addr, m_wdata;
  logic [7:0]  m_mask;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_mem_req", bus.mem_req, 0);
      chk("rst_if_gnt", bus.if_gnt, 0);
      chk("rst_dm_gnt", bus.dm_gnt, 0);
      chk("rst_if_rvalid", bus.if_rvalid, 0);
      chk("rst_dm_rvalid", bus.dm_rvalid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_dm_rdata", bus.dm_rdata, 0);
      owner = 0; streak = 0; e_if_gnt = 1'b0; e_dm_gnt = 1'b0;
    end else begin
      m_pick_if = bus.if_req && !bus.if_flush && (!bus.dm_req || streak >= MAXS);
      m_pick_dm = bus.dm_req && !m_pick_if;
      m_req     = (owner == 0 || bus.mem_rvalid) && (m_pick_if || m_pick_dm);
      e_if_gnt  = m_req && bus.mem_gnt && m_pick_if;
      e_dm_gnt  = m_req && bus.mem_gnt && m_pick_dm;
      m_we      = m_pick_dm ? bus.dm_we : 1'b0;
      m_addr    = m_pick_dm ? bus.dm_addr : (m_pick_if ? bus.if_addr : 64'h0);
      m_mask    = m_pick_dm ? bus.dm_wmask : 8'h0;
      m_wdata   = m_pick_dm ? bus.dm_wdata : 64'h0;
      m_ifrv    = bus.mem_rvalid && owner == 1 && !bus.if_flush;
      m_dmrv    = bus.mem_rvalid && owner == 2;
      chk("mem_req", bus.mem_req, m_req);
      chk("if_gnt", bus.if_gnt, e_if_gnt);
      chk("dm_gnt", bus.dm_gnt, e_dm_gnt);
      chk("mem_we", bus.mem_we, m_we);
      chk("mem_addr", bus.mem_addr, m_addr);
      chk("mem_wmask", bus.mem_wmask, m_mask);
      chk("mem_wdata", bus.mem_wdata, m_wdata);
      chk("if_rvalid", bus.if_rvalid, m_ifrv);
      chk("dm_rvalid", bus.dm_rvalid, m_dmrv);
      chk("busy", bus.busy, owner != 0);
      if (m_ifrv) chk("if_rdata", bus.if_rdata, bus.mem_rdata);
      if (m_dmrv) chk("dm_rdata", bus.dm_rdata, bus.mem_rdata);
      if (e_if_gnt)                       owner = 1;
      else if (e_dm_gnt)                  owner = 2;
      else if (bus.mem_rvalid)            owner = 0;
      else if (owner == 1 && bus.if_flush) owner = 3;
      if (e_if_gnt || !bus.if_req)       streak = 0;
      else if (e_dm_gnt && streak < MAXS) streak = streak + 1;
    end
  end

  task automatic idle_inputs();
    bus.if_req = 0; bus.if_addr = '0; bus.if_flush = 0;
    bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = '0; bus.dm_wmask = '0; bus.dm_wdata = '0;
    bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [9:0] dmv, ifv;
  int         nreq;
  int         resp_cnt;

  initial begin
    // Reset holds every output low even with live requests and a response.
    idle_inputs();
    bus.if_req = 1; bus.dm_req = 1; bus.mem_gnt = 1; bus.mem_rvalid = 1;
    bus.mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    step(); #3;
    chk("reset_mem_req", bus.mem_req, 0);
    chk("reset_dm_gnt", bus.dm_gnt, 0);
    chk("reset_dm_rdata", bus.dm_rdata, 0);
    idle_inputs();
    step(); rst = 0;

    // Single fetch with 1-cycle memory
    step(); bus.if_req = 1; bus.if_addr = 64'h1000; bus.mem_gnt = 1; #3;
    chk("fetch_gnt", bus.if_gnt, 1);
    chk("fetch_addr", bus.mem_addr, 64'h1000);
    chk("fetch_busy_c0", bus.busy, 0);
    step(); bus.if_req = 0; bus.mem_rvalid = 1; bus.mem_rdata = 64'hDEAD; #3;
    chk("fetch_rvalid", bus.if_rvalid, 1);
    chk("fetch_rdata", bus.if_rdata, 64'hDEAD);
    chk("fetch_busy_c1", bus.busy, 1);
    step(); bus.mem_rvalid = 0; #3;
    chk("fetch_busy_c2", bus.busy, 0);

    // Contention and starvation: DM wins 4 times, then IF, then DM again
    dmv = '0; ifv = '0; nreq = 0;
    step(); bus.dm_req = 1; bus.dm_addr = 64'h2000; bus.if_req = 1; bus.if_addr = 64'h1008;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) step();
      bus.mem_rvalid = (i > 0);
      #3;
      dmv[i] = bus.dm_gnt;
      ifv[i] = bus.if_gnt;
      if (bus.mem_req) nreq++;
    end
    chk("starve_dm_pattern", {54'h0, dmv}, 64'h1EF);
    chk("starve_if_pattern", {54'h0, ifv}, 64'h210);
    chk("starve_back_to_back", nreq, 10);
    step(); bus.if_req = 0; bus.dm_req = 0; bus.mem_rdata = 64'h77; #3;
    chk("starve_if_rvalid", bus.if_rvalid, 1);
    step(); bus.mem_rvalid = 0; #3;
    chk("starve_idle", bus.busy, 0);

    // Flush a 3-cycle fetch; DM issues as the dropped response arrives
    step(); bus.if_req = 1; bus.if_addr = 64'h3000; #3;
    chk("flush_gnt", bus.if_gnt, 1);
    step(); bus.if_req = 0; bus.if_flush = 1; #3;
    chk("flush_no_rvalid_c1", bus.if_rvalid, 0);
    step(); bus.if_flush = 0; bus.dm_req = 1; bus.dm_addr = 64'h4000; #3;
    chk("flush_drop_busy", bus.busy, 1);
    chk("flush_drop_no_gnt", bus.dm_gnt, 0);
    step(); bus.mem_rvalid = 1; bus.mem_rdata = 64'hBEEF; #3;
    chk("flush_dropped_rvalid", bus.if_rvalid, 0);
    chk("flush_dm_gnt", bus.dm_gnt, 1);
    chk("flush_dm_addr", bus.mem_addr, 64'h4000);
    step(); bus.dm_req = 0; bus.mem_rdata = 64'h55; #3;
    chk("flush_dm_rvalid", bus.dm_rvalid, 1);
    chk("flush_dm_rdata", bus.dm_rdata, 64'h55);
    step(); bus.mem_rvalid = 0;

    // Store held through a 5-cycle mem_gnt stall, then acknowledged
    bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 64'h5000; bus.dm_wmask = 8'h0F;
    bus.dm_wdata = 64'h1122334455667788; bus.mem_gnt = 0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) step();
      #3;
      chk("stall_req_held", bus.mem_req, 1);
      chk("stall_no_gnt", bus.dm_gnt, 0);
    end
    step(); bus.mem_gnt = 1; #3;
    chk("store_gnt", bus.dm_gnt, 1);
    chk("store_we", bus.mem_we, 1);
    chk("store_wmask", bus.mem_wmask, 64'h0F);
    chk("store_wdata", bus.mem_wdata, 64'h1122334455667788);
    step(); bus.dm_req = 0; bus.dm_we = 0; bus.mem_rvalid = 1; #3;
    chk("store_ack", bus.dm_rvalid, 1);
    step(); bus.mem_rvalid = 0;

    // Asynchronous reset inside DM_WAIT, then a stray response
    bus.dm_req = 1; bus.dm_addr = 64'h6000; #3;
    chk("areset_dm_gnt", bus.dm_gnt, 1);
    step(); #1; rst = 1; #1;
    chk("areset_busy", bus.busy, 0);
    chk("areset_mem_req", bus.mem_req, 0);
    step(); rst = 0; bus.dm_req = 0; bus.mem_rvalid = 1; #3;
    chk("stray_no_rvalid", bus.dm_rvalid, 0);
    chk("stray_busy", bus.busy, 0);
    step(); bus.mem_rvalid = 0;

    // Randomized traffic with variable memory latency and stalls
    step(); rst = 1; idle_inputs();
    step(); rst = 0;
    resp_cnt = 0;
    for (int c = 0; c < 4000; c++) begin
      step();
      if (e_if_gnt || e_dm_gnt) resp_cnt = $urandom_range(1, 4);
      bus.mem_rvalid = 0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) bus.mem_rvalid = 1;
      end
      bus.mem_rdata = {$urandom, $urandom};
      bus.mem_gnt   = ($urandom_range(0, 3) != 0);
      if (!bus.if_req || e_if_gnt || bus.if_flush) begin
        bus.if_req  = ($urandom_range(0, 3) != 0);
        bus.if_addr = {$urandom, $urandom} & ~64'h3;
      end
      bus.if_flush = ($urandom_range(0, 9) == 0);
      if (!bus.dm_req || e_dm_gnt) begin
        bus.dm_req   = ($urandom_range(0, 2) != 0);
        bus.dm_we    = 1'($urandom_range(0, 1));
        bus.dm_addr  = {$urandom, $urandom} & ~64'h7;
        bus.dm_wmask = 8'($urandom);
        bus.dm_wdata = {$urandom, $urandom};
      end
    end

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported 64-bit memory between the instruction-fetch (IF) requester and the data-memory (DM) load/store requester of the RV64I core.
- Allows one outstanding memory transaction at a time.
- DM has priority, bounded by an anti-starvation streak limit for IF.
- An IF request in flight can be flushed on a taken branch/jump; its late response is dropped.

Parameters:
- AW, 64, address width in bits.
- DW, 64, data width in bits. Byte-mask width is DW/8.
- MAX_DM_STREAK, 4, maximum consecutive DM grants while IF is waiting; then IF is forced.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  AW  fetch address
- if_flush  in  1  cancel the current or in-flight fetch
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  fetch data valid
- if_rdata  out  DW  fetch data
- dm_req  in  1  data request; held stable until dm_gnt
- dm_we  in  1  1 = store
- dm_addr  in  AW  data address
- dm_wmask  in  DW/8  byte write mask
- dm_wdata  in  DW  store data
- dm_gnt  out  1  data request accepted
- dm_rvalid  out  1  load data valid / store acknowledge
- dm_rdata  out  DW  load data
- mem_req  out  1  request to memory
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wmask  out  DW/8  memory byte mask
- mem_wdata  out  DW  memory write data
- mem_gnt  in  1  memory accepts request this cycle
- mem_rvalid  in  1  response; one per accepted request, reads and writes
- mem_rdata  in  DW  read data
- busy  out  1  a transaction is outstanding

Behaviour:
- States: IDLE, IF_WAIT, DM_WAIT, IF_DROP. Reset enters IDLE with dm_streak = 0.
- Reset values: all outputs 0 during reset.
- Reset mid-transaction: returns to IDLE immediately. Any later stray mem_rvalid while in IDLE is ignored.
- Issue window: `can_issue = (state == IDLE) | mem_rvalid`. This allows back-to-back issue in the cycle a response arrives.
- Candidate selection (combinational):
  - if_ok = if_req & ~if_flush.
  - pick_if = if_ok & (~dm_req | dm_streak >= MAX_DM_STREAK).
  - pick_dm = dm_req & ~pick_if.
- mem_req = can_issue & (pick_if | pick_dm).
- mem_we, mem_addr, mem_wmask, mem_wdata are muxed from the picked requester. When IF is picked, mem_we = 0 and mem_wmask = 0. When nothing is picked, all are 0.
- if_gnt = mem_req & mem_gnt & pick_if. dm_gnt likewise with pick_dm. Both are never high together.
- Next state:
  - Grant to IF → IF_WAIT.
  - Grant to DM → DM_WAIT.
  - mem_rvalid with no new grant → IDLE.
  - mem_rvalid and no grant while in IDLE → stay IDLE.
- Responses (combinational pass-through):
  - if_rvalid = mem_rvalid & (state == IF_WAIT) & ~if_flush.
  - dm_rvalid = mem_rvalid & (state == DM_WAIT).
  - rdata is routed to both; it is meaningful only when the matching rvalid is high.
- Flush:
  - if_flush in IF_WAIT without mem_rvalid → IF_DROP.
  - In IF_DROP, mem_rvalid is consumed with no if_rvalid.
  - Flush in the same cycle as the response suppresses if_rvalid.
  - Flush in IDLE only blocks IF issue that cycle.
- dm_streak (saturating at MAX_DM_STREAK):
  - +1 on dm_gnt while if_req is high.
  - Cleared on if_gnt or when if_req is low.
- busy = (state != IDLE).
- Latency: grant in cycle N, response at the earliest in N+1. Memory stalls are tolerated indefinitely.

Decomposition:
- Package DEF gains:
  - `arb_state_t` enum {IDLE, IF_WAIT, DM_WAIT, IF_DROP}.
  - `ARB_STREAK_W` = $clog2(MAX_DM_STREAK+1).
- One sub-module, `mem_arb_pick`: purely combinational. Takes if_ok, dm_req, streak_sat and produces pick_if/pick_dm. It is unit-testable on its own.
- FSM, streak counter and muxes stay in the top module.

Test Plan:
- Single fetch: if_req, addr 0x1000; mem_gnt = 1; 1-cycle memory returning 0xDEAD → if_gnt at cycle 0, if_rvalid with if_rdata 0xDEAD at cycle 1, busy high only for cycle 1.
- Contention: if_req and dm_req both high with a load at 0x2000 → dm_gnt first. IF is granted in the cycle DM's response arrives (back-to-back, mem_req never drops).
- Starvation: dm_req held high for 10 requests with if_req high, 1-cycle memory → IF granted after exactly 4 DM grants; dm_streak returns to 0.
- Flush: IF granted, memory latency 3, if_flush pulsed at cycle 1 → state IF_DROP; no if_rvalid; dm request granted in the cycle the dropped response arrives.
- Store ack: dm_we = 1, wmask 0x0F, wdata 0x1122334455667788 → mem_wmask 0x0F, dm_rvalid pulse one cycle after grant. Stall mem_gnt low for 5 cycles → request held, no gnt.
- Async reset asserted in DM_WAIT mid-cycle → all outputs 0 immediately. Following stray mem_rvalid → no dm_rvalid.
